uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the single host-bound UART transmitter between NUM_SRC receive FIFOs (PINT, discrete I2C, future interfaces). Each completed inbound message is framed as one ASCII line (a per-source prefix character, hex-encoded FIFO bytes, then `0x0A`), and sources are served round-robin. Sits between the interface RX FIFOs and the `uart` TX port in the ICE controller, replacing ad-hoc per-interface RX sequencing.

## Interface
Parameters:
- NUM_SRC, 2, number of requesting sources (2..8)
- MAX_BYTES, 16, maximum bytes emitted per line (1..255)
- PEND_W, 2, width of the per-source saturating pending-message counter

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- src_req  in  NUM_SRC  1-cycle pulse per source: one complete message is now in its FIFO
- src_prefix  in  8*NUM_SRC  static prefix character per source; source i uses bits [8i+7:8i]
- src_data  in  8*NUM_SRC  FIFO head byte per source
- src_valid  in  NUM_SRC  FIFO non-empty per source
- src_pop  out  NUM_SRC  1-cycle FIFO pop strobe per source
- uart_tx_empty  in  1  UART able to accept a character
- uart_tx_latch  out  1  1-cycle character strobe to UART
- uart_tx_data  out  8  character, valid while uart_tx_latch is high
- grant  out  NUM_SRC  one-hot source currently being sent; all zero when idle
- busy  out  1  high in every state except IDLE
- pend_ovf  out  1  sticky: a src_req arrived while that source's counter was saturated

## Operation
- Pending counters: per source; +1 on src_req, −1 when that source is granted; a simultaneous +1/−1 leaves the counter unchanged. Saturate at 2^PEND_W−1; a request at saturation is dropped and sets pend_ovf, which only reset clears.
- Arbitration: in IDLE, pick the first source with pending>0, searching from last_grant+1 upward with wrap-around. last_grant resets to NUM_SRC−1, so source 0 wins the first tie.
- FSM states: IDLE, PREFIX, HI, LO, EOL.
  - IDLE: if any source is pending, register grant, clear byte_cnt, go to PREFIX.
  - PREFIX: send the src_prefix character, then go to HI.
  - HI: if byte_cnt==MAX_BYTES or the granted src_valid is low, go to EOL without sending. Otherwise send hex(data[7:4]) and go to LO.
  - LO: send hex(data[3:0]) and assert src_pop[grant] in the same cycle. byte_cnt+1, go to HI.
  - EOL: send `0x0A`, clear grant, update last_grant, go to IDLE.
- "Send" means: uart_tx_latch=1 and uart_tx_data=char in a cycle where uart_tx_empty=1 and holdoff=0. The state advances on that edge. If those conditions are not met, the FSM stays in its state.
- Hex encoding: 0–9 → `0x30`–`0x39`; a–f → `0x61`–`0x66` (lowercase).
- A message with an empty FIFO produces prefix plus `0x0A` only.
- A MAX_BYTES cut leaves the remaining bytes in the FIFO. They are emitted at the start of that source's next granted line. No extra pending count is added.
- src_pop is only ever asserted for the granted source. src_data and src_valid of non-granted sources are ignored.

## Timing
- Reset (asynchronous, reset=0): state IDLE; grant=0, busy=0, uart_tx_latch=0, uart_tx_data=0, src_pop=0, pend_ovf=0; all counters 0; last_grant=NUM_SRC−1.
- Reset mid-line: the line is abandoned immediately and no `0x0A` is sent. FIFO contents are untouched.
- uart_tx_latch, uart_tx_data and src_pop are combinational from registered state, uart_tx_empty and holdoff.
- holdoff is a register set for exactly one cycle after every uart_tx_latch. It:
  - absorbs the UART's tx_empty deassert latency;
  - lets the FIFO head update after a pop before HI samples it.
- Maximum character rate: one every 2 cycles.
- Latency:
  - src_req at cycle 0 → pending at edge 1 → grant at edge 2 → prefix latch in cycle 2 if uart_tx_empty=1.
  - The decision in HI to skip to EOL takes 1 cycle.
- Line length: 2+2·n characters for n bytes, where n ≤ MAX_BYTES.
- A src_req for the source currently being sent only increments its counter. It is served again after at most NUM_SRC−1 other lines.

## Test plan
- Single source: source 0 with prefix `0x61`, FIFO holding 0x3C,0xA5, one src_req, uart_tx_empty=1 → characters `a`,`3`,`c`,`a`,`5`,`0x0A`; src_pop pulses twice, each coincident with a low-nibble latch; busy drops after `0x0A`.
- Round-robin: src_req for sources 0 and 1 in the same cycle, then another req on 0 during line 1 → line order 0,1,0; grant one-hot throughout.
- Empty and limit: req with an empty FIFO → prefix,`0x0A`. With MAX_BYTES=2 and 3 bytes queued → 2 bytes, EOL, then the third byte leads the next line.
- Backpressure: uart_tx_empty held low for 10 cycles during HI → no latch, no pop, state held; resumes correctly with no duplicated or skipped character.
- Overflow: PEND_W=2 and 4 reqs on one source while it is blocked → counter 3, pend_ovf=1; exactly 3 lines are emitted.
- Reset: assert reset during LO → all outputs 0 the same cycle. After release, a new req produces a clean line; the next grant goes to source 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one host-bound UART transmitter between NUM_SRC receive FIFOs.
// Each completed inbound message is sent as one ASCII line: the source's
// prefix character, the FIFO bytes as lowercase hex pairs, then 0x0A.
// Sources with pending messages are served round-robin.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-low reset
//   src_req        per-source 1-cycle pulse: one complete message is queued
//   src_prefix     per-source static prefix character, source i at [8i+7:8i]
//   src_data       per-source FIFO head byte
//   src_valid      per-source FIFO non-empty
//   src_pop        per-source 1-cycle FIFO pop strobe (granted source only)
//   uart_tx_empty  UART can accept a character
//   uart_tx_latch  1-cycle character strobe to the UART
//   uart_tx_data   character, valid while uart_tx_latch is high (0 otherwise)
//   grant          one-hot source being sent, zero when idle
//   busy           high in every state except IDLE
//   pend_ovf       sticky: a request was dropped on a saturated counter
//   dbg_state      current FSM state (IDLE=0 PREFIX=1 HI=2 LO=3 EOL=4)
//
// Handshake: a character is transferred in any cycle where uart_tx_latch
// is high; that only happens when uart_tx_empty=1 and holdoff is clear,
// and the FSM advances on the same clock edge.
module uart_tx_arbiter #(
    parameter int NUM_SRC   = 2,
    parameter int MAX_BYTES = 16,
    parameter int PEND_W    = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_SRC-1:0]     src_req,
    input  logic [8*NUM_SRC-1:0]   src_prefix,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_valid,
    output logic [NUM_SRC-1:0]     src_pop,
    input  logic                   uart_tx_empty,
    output logic                   uart_tx_latch,
    output logic [7:0]             uart_tx_data,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic                   pend_ovf,
    output logic [2:0]             dbg_state
);

    localparam int                IW       = $clog2(NUM_SRC);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;
    localparam logic [7:0]        BYTE_LIM = 8'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PREFIX = 3'd1,
        S_HI     = 3'd2,
        S_LO     = 3'd3,
        S_EOL    = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [IW-1:0]     last_q, last_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              holdoff_q;
    logic [PEND_W-1:0] pend_q [NUM_SRC];
    logic              ovf_q;

    logic [NUM_SRC-1:0] pend_inc, pend_dec, sat_hit;
    logic               pick_found;
    logic [IW-1:0]      pick_idx;
    logic               can_send, hi_skip;
    logic [7:0]         cur_data, cur_prefix, ch;
    logic               cur_valid;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        // 0x57 + 10 = 'a'
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    assign cur_data   = src_data[{idx_q, 3'b000} +: 8];
    assign cur_prefix = src_prefix[{idx_q, 3'b000} +: 8];
    assign cur_valid  = src_valid[idx_q];
    // holdoff masks the cycle after each latch: UART empty deassert
    // latency, and the FIFO head refreshing after a pop.
    assign can_send   = uart_tx_empty && !holdoff_q;
    assign hi_skip    = (cnt_q == BYTE_LIM) || !cur_valid;

    assign busy      = (state_q != S_IDLE);
    assign grant     = busy ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << idx_q) : '0;
    assign pend_ovf  = ovf_q;
    assign dbg_state = state_q;

    // Round-robin pick: first pending source after last_grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int cand;
            cand = (int'(last_q) + k) % NUM_SRC;
            if (!pick_found && pend_q[IW'(cand)] != '0) begin
                pick_found = 1'b1;
                pick_idx   = IW'(cand);
            end
        end
    end

    always_comb begin
        pend_inc = '0;
        pend_dec = '0;
        sat_hit  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pend_inc[i] = src_req[i] && (pend_q[i] != PEND_MAX);
            sat_hit[i]  = src_req[i] && (pend_q[i] == PEND_MAX);
            pend_dec[i] = (state_q == S_IDLE) && pick_found && (pick_idx == IW'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SRC; i++) pend_q[i] <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (pend_inc[i] && !pend_dec[i])
                    pend_q[i] <= pend_q[i] + 1'b1;
                else if (!pend_inc[i] && pend_dec[i])
                    pend_q[i] <= pend_q[i] - 1'b1;
            end
            ovf_q <= ovf_q | (|sat_hit);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            last_q    <= IW'(NUM_SRC - 1);
            cnt_q     <= '0;
            holdoff_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            holdoff_q <= uart_tx_latch;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    state_d = S_PREFIX;
                end
            end
            S_PREFIX: if (can_send) state_d = S_HI;
            S_HI: begin
                // The skip to EOL does not wait for the UART.
                if (hi_skip)       state_d = S_EOL;
                else if (can_send) state_d = S_LO;
            end
            S_LO: begin
                if (can_send) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = S_HI;
                end
            end
            S_EOL: begin
                if (can_send) begin
                    last_d  = idx_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        uart_tx_latch = 1'b0;
        ch            = 8'h00;
        src_pop       = '0;
        case (state_q)
            S_PREFIX: begin
                uart_tx_latch = can_send;
                ch            = cur_prefix;
            end
            S_HI: begin
                uart_tx_latch = can_send && !hi_skip;
                ch            = hex_char(cur_data[7:4]);
            end
            S_LO: begin
                uart_tx_latch = can_send;
                ch            = hex_char(cur_data[3:0]);
                src_pop       = can_send ? grant : '0;
            end
            S_EOL: begin
                uart_tx_latch = can_send;
                ch            = 8'h0A;
            end
            default: ;
        endcase
        uart_tx_data = uart_tx_latch ? ch : 8'h00;
    end

endmodule
